// File: rtl/ecdsa_pkg.sv
// Shared ECDSA definitions: controller state encodings and the secp256k1 domain constants.
package ecdsa_pkg;

  typedef enum logic [2:0] {
    IDLE, SCAN, DBL_GO, DBL_WAIT, ADD_GO, ADD_WAIT, NEXT, FIN
  } sm_state_t;

  typedef enum logic [2:0] {
    PT_PREP, PT_INV, PT_X, PT_Y, PT_HOLD
  } pt_state_t;

  localparam logic [255:0] SECP_P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [255:0] SECP_GX =
    256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
  localparam logic [255:0] SECP_GY =
    256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;
  localparam logic [255:0] SECP_ORDER =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;

endpackage

// File: rtl/ec_point_core.sv
// Affine point add/double engine (curve a = 0): lambda via binary extended Euclid inverse.
// Operands are captured while reset is high; result or infinity then rises and holds until the next reset.
module ec_point_core
  import ecdsa_pkg::*;
#(
  parameter int n     = 256,
  parameter bit dbl   = 1'b0,
  parameter int steps = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n-1:0] p,
  input  logic [n-1:0] x1,
  input  logic [n-1:0] y1,
  input  logic [n-1:0] x2,
  input  logic [n-1:0] y2,
  output logic [n-1:0] x3,
  output logic [n-1:0] y3,
  output logic         result,
  output logic         infinity
);

  localparam logic [n-1:0] ONE = {{(n-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [n-1:0] u;
    logic [n-1:0] v;
    logic [n-1:0] g1;
    logic [n-1:0] g2;
  } inv_t;

  pt_state_t    st;
  logic [n-1:0] ax1, ay1, ax2, ay2, num, lam;
  logic [n-1:0] sq, num_c, den_c;
  inv_t         iv, iv_nxt;

  function automatic logic [n-1:0] mod_add(input logic [n-1:0] a, b, m);
    logic [n:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return n'(s);
  endfunction

  function automatic logic [n-1:0] mod_sub(input logic [n-1:0] a, b, m);
    return (a >= b) ? a - b : a - b + m;
  endfunction

  function automatic logic [n-1:0] mod_mul(input logic [n-1:0] a, b, m);
    logic [2*n-1:0] pr;
    pr = {{n{1'b0}}, a} * {{n{1'b0}}, b};
    return n'(pr % {{n{1'b0}}, m});
  endfunction

  function automatic logic [n-1:0] half(input logic [n-1:0] a, m);
    logic [n:0] t;
    t = {1'b0, a} + (a[0] ? {1'b0, m} : '0);
    return n'(t >> 1);
  endfunction

  // Invariants: g1*den == u and g2*den == v (mod p); stops once either side reaches 1.
  function automatic inv_t inv_step(input inv_t s, input logic [n-1:0] m);
    inv_t r;
    r = s;
    if (s.u == ONE || s.v == ONE) begin
      r = s;
    end else if (!s.u[0]) begin
      r.u  = s.u >> 1;
      r.g1 = half(s.g1, m);
    end else if (!s.v[0]) begin
      r.v  = s.v >> 1;
      r.g2 = half(s.g2, m);
    end else if (s.u >= s.v) begin
      r.u  = s.u - s.v;
      r.g1 = mod_sub(s.g1, s.g2, m);
    end else begin
      r.v  = s.v - s.u;
      r.g2 = mod_sub(s.g2, s.g1, m);
    end
    return r;
  endfunction

  always_comb begin
    iv_nxt = iv;
    for (int i = 0; i < steps; i++) iv_nxt = inv_step(iv_nxt, p);
  end

  always_comb begin
    sq    = '0;
    num_c = '0;
    den_c = '0;
    if (dbl) begin
      sq    = mod_mul(ax1, ax1, p);
      num_c = mod_add(mod_add(sq, sq, p), sq, p);
      den_c = mod_add(ay1, ay1, p);
    end else begin
      num_c = mod_sub(ay2, ay1, p);
      den_c = mod_sub(ax2, ax1, p);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= PT_PREP;
      result   <= 1'b0;
      infinity <= 1'b0;
      ax1      <= x1;
      ay1      <= y1;
      ax2      <= x2;
      ay2      <= y2;
    end else begin
      case (st)
        PT_PREP: begin
          if (den_c == '0) begin
            infinity <= 1'b1;
            st       <= PT_HOLD;
          end else begin
            num <= num_c;
            iv  <= '{u: den_c, v: p, g1: ONE, g2: '0};
            st  <= PT_INV;
          end
        end
        PT_INV: begin
          if (iv.u == ONE || iv.v == ONE) begin
            lam <= mod_mul(num, (iv.u == ONE) ? iv.g1 : iv.g2, p);
            st  <= PT_X;
          end else begin
            iv <= iv_nxt;
          end
        end
        PT_X: begin
          x3 <= mod_sub(mod_sub(mod_mul(lam, lam, p), ax1, p), ax2, p);
          st <= PT_Y;
        end
        PT_Y: begin
          y3     <= mod_sub(mod_mul(lam, mod_sub(ax1, x3, p), p), ay1, p);
          result <= 1'b1;
          st     <= PT_HOLD;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/point_addition.sv
// Affine point addition R3 = R1 + R2 for distinct x coordinates; x1 == x2 reports infinity.
module point_addition #(
  parameter int n = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n-1:0] p,
  input  logic [n-1:0] x1,
  input  logic [n-1:0] y1,
  input  logic [n-1:0] x2,
  input  logic [n-1:0] y2,
  output logic [n-1:0] x3,
  output logic [n-1:0] y3,
  output logic         result,
  output logic         infinity
);

  ec_point_core #(.n(n), .dbl(1'b0)) u_core (
    .clk(clk), .reset(reset), .p(p),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .x3(x3), .y3(y3), .result(result), .infinity(infinity)
  );

endmodule

// File: rtl/point_doubling.sv
// Affine point doubling R3 = 2*R1 on a = 0 curves; y1 == 0 reports infinity.
module point_doubling #(
  parameter int n = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n-1:0] p,
  input  logic [n-1:0] x1,
  input  logic [n-1:0] y1,
  output logic [n-1:0] x3,
  output logic [n-1:0] y3,
  output logic         result,
  output logic         infinity
);

  ec_point_core #(.n(n), .dbl(1'b1)) u_core (
    .clk(clk), .reset(reset), .p(p),
    .x1(x1), .y1(y1), .x2(x1), .y2(y1),
    .x3(x3), .y3(y3), .result(result), .infinity(infinity)
  );

endmodule

// File: rtl/scalar_multiplication.sv
// Left-to-right double-and-add Q = k*P; point math is delegated to point_doubling / point_addition,
// each launched by a one-cycle active-high reset pulse with operands already stable.
module scalar_multiplication
  import ecdsa_pkg::*;
#(
  parameter int n = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] p,
  input  logic [n-1:0] k,
  input  logic [n-1:0] xp,
  input  logic [n-1:0] yp,
  output logic [n-1:0] xq,
  output logic [n-1:0] yq,
  output logic         busy,
  output logic         done,
  output logic         infinity
);

  localparam int IW = $clog2(n);

  sm_state_t    state;
  logic [n-1:0] kl, xpl, ypl, xr, yr;
  logic         r_inf, hit, from_add;
  logic [IW-1:0] idx, idx_m1;

  logic         dbl_launch, add_launch;
  logic [n-1:0] dbl_x, dbl_y, add_x, add_y;
  logic         dbl_res, dbl_inf, add_res, add_inf;

  assign idx_m1     = idx - IW'(1);
  assign dbl_launch = (state == DBL_GO);
  assign add_launch = (state == ADD_GO) && !r_inf && (xr != xpl);

  point_doubling #(.n(n)) u_dbl (
    .clk(clk), .reset(!reset || dbl_launch), .p(p),
    .x1(xr), .y1(yr),
    .x3(dbl_x), .y3(dbl_y), .result(dbl_res), .infinity(dbl_inf)
  );

  point_addition #(.n(n)) u_add (
    .clk(clk), .reset(!reset || add_launch), .p(p),
    .x1(xr), .y1(yr), .x2(xpl), .y2(ypl),
    .x3(add_x), .y3(add_y), .result(add_res), .infinity(add_inf)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      infinity <= 1'b0;
      xq       <= '0;
      yq       <= '0;
      kl       <= '0;
      xpl      <= '0;
      ypl      <= '0;
      xr       <= '0;
      yr       <= '0;
      r_inf    <= 1'b0;
      hit      <= 1'b0;
      from_add <= 1'b0;
      idx      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            kl    <= k;
            xpl   <= xp;
            ypl   <= yp;
            xr    <= '0;
            yr    <= '0;
            r_inf <= 1'b1;
            idx   <= IW'(n - 1);
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (kl[idx]) begin
            xr    <= xpl;
            yr    <= ypl;
            r_inf <= 1'b0;
            state <= NEXT;
          end else if (idx == '0) begin
            state <= FIN;
          end else begin
            idx <= idx_m1;
          end
        end
        NEXT: begin
          if (idx == '0) begin
            state <= FIN;
          end else begin
            idx <= idx_m1;
            if (!r_inf)           state <= DBL_GO;
            else if (kl[idx_m1])  state <= ADD_GO;
            else                  state <= NEXT;
          end
        end
        DBL_GO: state <= DBL_WAIT;
        DBL_WAIT: begin
          if (hit) begin
            hit      <= 1'b0;
            from_add <= 1'b0;
            if (dbl_inf) r_inf <= 1'b1;
            else begin
              xr <= dbl_x;
              yr <= dbl_y;
            end
            // A doubling that stood in for R + P must not be followed by another add.
            state <= (kl[idx] && !from_add) ? ADD_GO : NEXT;
          end else if (dbl_res || dbl_inf) begin
            hit <= 1'b1;
          end
        end
        ADD_GO: begin
          if (r_inf) begin
            xr    <= xpl;
            yr    <= ypl;
            r_inf <= 1'b0;
            state <= NEXT;
          end else if (xr == xpl) begin
            if (yr == ypl) begin
              from_add <= 1'b1;
              state    <= DBL_GO;
            end else begin
              r_inf <= 1'b1;
              state <= NEXT;
            end
          end else begin
            state <= ADD_WAIT;
          end
        end
        ADD_WAIT: begin
          if (hit) begin
            hit <= 1'b0;
            if (add_inf) r_inf <= 1'b1;
            else begin
              xr <= add_x;
              yr <= add_y;
            end
            state <= NEXT;
          end else if (add_res || add_inf) begin
            hit <= 1'b1;
          end
        end
        FIN: begin
          xq       <= r_inf ? '0 : xr;
          yq       <= r_inf ? '0 : yr;
          infinity <= r_inf;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scalar_multiplication.sv
// Scoreboard bench for scalar_multiplication on secp256k1 with hand-computed multiples of G.
module tb_scalar_multiplication;
  import ecdsa_pkg::*;

  localparam int N = 256;
  localparam logic [N-1:0] G2X =
    256'hc6047f94_41ed7d6d_3045406e_95c07cd8_5c778e4b_8cef3ca7_abac09b9_5c709ee5;
  localparam logic [N-1:0] G2Y =
    256'h1ae168fe_a63dc339_a3c58419_466ceaee_f7f63265_3266d0e1_236431a9_50cfe52a;
  localparam logic [N-1:0] G3X =
    256'hf9308a01_9258c310_49344f85_f89d5229_b531c845_836f99b0_8601f113_bce036f9;
  localparam logic [N-1:0] G3Y =
    256'h388f7b0f_632de814_0fe337e6_2a37f356_6500a999_34c2231b_6cb9fd75_84b8e672;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] p = SECP_P;
  logic [N-1:0] k = '0;
  logic [N-1:0] xp = '0;
  logic [N-1:0] yp = '0;
  logic [N-1:0] xq, yq;
  logic         busy, done, infinity;

  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         inf;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int total = 0, bad = 0, cyc = 0, t_start = 0, launches = 0, dones = 0;

  always #5 clk = ~clk;

  scalar_multiplication #(.n(N)) dut (
    .clk(clk), .reset(reset), .start(start), .p(p), .k(k), .xp(xp), .yp(yp),
    .xq(xq), .yq(yq), .busy(busy), .done(done), .infinity(infinity)
  );

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial forever begin
    @(negedge clk);
    if (reset && (dut.dbl_launch || dut.add_launch)) launches = launches + 1;
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && done) begin
        dones++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: xq=%h infinity=%b with no request pending", xq, infinity);
        end else begin
          e = sb.pop_front();
          chk("xq", xq, e.x);
          chk("yq", yq, e.y);
          chk("infinity", N'(infinity), N'(e.inf));
          chk("busy_at_done", N'(busy), N'(1'b0));
          if (e.lat >= 0) chk("latency", N'(cyc - t_start), N'(e.lat));
        end
      end
    end
  end

  task automatic issue(input logic [N-1:0] kk, xx, yy, ex, ey, input logic einf,
                       input int lat, input bit push, input bit rel);
    @(negedge clk);
    if (rel) reset = 1'b1;
    k = kk;
    xp = xx;
    yp = yy;
    start = 1'b1;
    if (push) sb.push_back('{x: ex, y: ey, inf: einf, lat: lat});
    @(posedge clk);
    #1;
    start = 1'b0;
    t_start = cyc;
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while ((sb.size() != 0 || busy) && c < budget) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    if (c >= budget) begin
      total++;
      bad++;
      $display("FAIL timeout: pending=%0d busy=%b after %0d cycles", sb.size(), busy, c);
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "bench stopped on timeout");
    end
  endtask

  initial begin : main
    int l0, d0, c;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_xq", xq, '0);
    chk("rst_yq", yq, '0);
    chk("rst_busy", N'(busy), N'(1'b0));
    chk("rst_done", N'(done), N'(1'b0));
    chk("rst_infinity", N'(infinity), N'(1'b0));

    // start on the first edge after reset release; k=1 needs no point operation
    l0 = launches;
    issue(N'(1), SECP_GX, SECP_GY, SECP_GX, SECP_GY, 1'b0, -1, 1'b1, 1'b1);
    chk("busy_after_start", N'(busy), N'(1'b1));
    drain(2000);
    chk("k1_launches", N'(launches - l0), N'(0));

    issue('0, SECP_GX, SECP_GY, '0, '0, 1'b1, N + 1, 1'b1, 1'b0);
    drain(2000);

    issue(N'(2), SECP_GX, SECP_GY, G2X, G2Y, 1'b0, -1, 1'b1, 1'b0);
    drain(4000);

    issue(SECP_ORDER, SECP_GX, SECP_GY, '0, '0, 1'b1, -1, 1'b1, 1'b0);
    drain(60000);

    issue(N'(3), SECP_GX, SECP_GY, G3X, G3Y, 1'b0, -1, 1'b1, 1'b0);
    drain(4000);

    // asynchronous reset in the middle of a doubling
    issue(N'(3), SECP_GX, SECP_GY, '0, '0, 1'b0, -1, 1'b0, 1'b0);
    c = 0;
    while (dut.state != DBL_WAIT && c < 600) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (c >= 600) begin
      bad++;
      $display("FAIL reach_dbl_wait: waited %0d cycles, state=%0d", c, dut.state);
    end
    #1 reset = 1'b0;
    #1;
    chk("midrst_xq", xq, '0);
    chk("midrst_yq", yq, '0);
    chk("midrst_busy", N'(busy), N'(1'b0));
    chk("midrst_done", N'(done), N'(1'b0));
    chk("midrst_infinity", N'(infinity), N'(1'b0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    issue(N'(2), SECP_GX, SECP_GY, G2X, G2Y, 1'b0, -1, 1'b1, 1'b0);
    drain(4000);

    // second start while busy must be ignored
    d0 = dones;
    issue(N'(3), SECP_GX, SECP_GY, G3X, G3Y, 1'b0, -1, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    k = N'(1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    drain(4000);
    repeat (3) @(negedge clk);
    chk("single_done", N'(dones - d0), N'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scalar_multiplication.md
SCALAR_MULTIPLICATION -- requirements
Module: scalar_multiplication

Interface
REQ-001 SHALL have parameter n, default 256, giving the field/scalar width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, one-cycle request pulse; sampled only in IDLE.
REQ-005 SHALL have port p, input, n, prime modulus; held stable while busy.
REQ-006 SHALL have port k, input, n, scalar; latched on accepted start.
REQ-007 SHALL have ports xp and yp, input, n each, affine base point; latched on accepted start.
REQ-008 SHALL have ports xq and yq, output, n each, affine result Q = k·P.
REQ-009 SHALL have port busy, output, 1, high from the cycle after an accepted start until done.
REQ-010 SHALL have port done, output, 1, one-cycle pulse when xq/yq/infinity are valid.
REQ-011 SHALL have port infinity, output, 1, high with done when Q is the point at infinity.

Function
REQ-012 SHALL use left-to-right double-and-add: scan the latched k from bit n-1 down to bit 0 with a bit index counter.
REQ-013 SHALL hold accumulator R (xr, yr, r_inf); r_inf is set on accept.
REQ-014 SHALL skip leading zero bits in single cycles (SCAN); the first 1 bit loads R = P with r_inf = 0 and no point operation.
REQ-015 SHALL, for each later bit, compute R = 2R, then R = R + P when the bit is 1.
REQ-016 SHALL use states IDLE, SCAN, DBL_GO, DBL_WAIT, ADD_GO, ADD_WAIT, NEXT, FIN.
REQ-017 SHALL launch a sub-operation by holding the sub-module's active-high reset for exactly one cycle in *_GO, with operands already stable.
REQ-018 SHALL, in *_WAIT, wait for sub-module result or infinity and capture x3/y3/infinity one cycle after either asserts.
REQ-019 SHALL skip doubling when r_inf = 1, leaving R at infinity.
REQ-020 SHALL, on an add with r_inf = 1, set R = P without launching point_addition.
REQ-021 SHALL, on an add with xr = xp and yr = yp, route to the doubling path; with xr = xp and yr ≠ yp, set r_inf = 1 without launching.
REQ-022 SHALL, when a captured sub-result flags infinity, set r_inf = 1.
REQ-023 SHALL, after bit 0, enter FIN: drive xq/yq = xr/yr, or zero when r_inf = 1, set infinity = r_inf, and pulse done; then return to IDLE.
REQ-024 SHALL treat k = 0 as all-zero SCAN, returning infinity = 1 and xq = yq = 0 after n+1 cycles.
REQ-025 SHALL ignore start while busy; xq/yq/infinity SHALL hold until the next accepted start.
REQ-026 SHALL NOT reduce k modulo the group order, and SHALL NOT check that P lies on the curve.

Reset
REQ-027 SHALL, on reset low at any time including mid-operation, asynchronously force IDLE, busy = 0, done = 0, infinity = 0, xq = yq = 0, clear the latched k/P/R, and hold both sub-modules in reset.
REQ-028 SHALL accept a start on the first clock edge after reset deasserts.

Structure
REQ-029 SHALL keep the state encodings and the secp256k1 constants (p, Gx, Gy, group order) in a shared ecdsa package used by the benches.
REQ-030 SHALL instantiate the existing point_addition and the existing point_doubling (ports clk, reset, p, x1, y1, x3, y3, result, infinity); it SHALL contain no modular arithmetic itself.

Verification
REQ-031 k=1, P=G (79be667e…16f81798, 483ada77…fb10d4b8) -> done with xq/yq = G, infinity=0, and no sub-module launched.
REQ-032 k=2, P=G -> xq=c6047f9441ed7d6d3045406e95c07cd85c778e4b8cef3ca7abac09b95c709ee5, yq=1ae168fea63dc339a3c58419466ceaeef7f632653266d0e1236431a950cfe52a.
REQ-033 k=3, P=G -> xq=f9308a019258c31049344f85f89d5229b531c845836f99b08601f113bce036f9, yq=388f7b0f632de8140fe337e62a37f3566500a99934c2231b6cb9fd7584b8e672.
REQ-034 k=0 -> done after n+1 cycles with infinity=1 and xq=yq=0; k = group order with P=G -> infinity=1.
REQ-035 Start k=3, pulse reset low during DBL_WAIT -> outputs zero immediately; a fresh start with k=2 then gives the REQ-032 values.
REQ-036 A second start pulse while busy -> ignored; a single done pulse with the first request's result.
